word_red_final_sub: RTL

- Downstream consumer of the word-level Montgomery reduction stage.
- Takes the partially reduced value T (K-R bits, R = Q_LEN-TL_LEN) and the modulus high word qH.
- Fully reduces T modulo q = {qH, R'b0} + 1 into [0, q) by restoring shift-and-subtract, one conditional subtraction per cycle.
- Valid/ready handshakes on both sides; one operation in flight.

---
 rtl/word_red_final_sub.sv | 100 ++++++++++
 1 files changed

// File: rtl/word_red_final_sub.sv
// Final modular reduction after the word-level Montgomery stage: reduces a TW-bit T
// into [0, q) with q = {qH, R'b0} + 1, one restoring conditional subtraction per cycle.
module word_red_final_sub #(
    parameter int K      = 128,
    parameter int Q_LEN  = 64,
    parameter int TL_LEN = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TL_LEN-1:0] qH,
    input  logic [K-Q_LEN+TL_LEN-1:0] T,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Q_LEN-1:0]  res,
    output logic [1:0]        dbg_state
);
    localparam int R  = Q_LEN - TL_LEN;
    localparam int TW = K - R;
    localparam int NS = TW - Q_LEN + 1;
    localparam int CW = $clog2(NS);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in IDLE, out_valid only in DONE, and neither depends
    // combinationally on the opposite side's signal.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [TW:0]      rem;
    logic [Q_LEN-1:0] qreg;
    logic [TW:0]      qsh;
    logic [TW:0]      diff;
    logic [TW:0]      rem_nxt;

    // q shifted by at most NS-1 still fits in TW bits, so the extra MSB is a clean borrow.
    always_comb begin
        qsh     = {{(TW + 1 - Q_LEN){1'b0}}, qreg} << cnt;
        diff    = rem - qsh;
        rem_nxt = diff[TW] ? rem : diff;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            qreg      <= '0;
            res       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem      <= {1'b0, T};
                        qreg     <= {qH, {R{1'b0}}} + Q_LEN'(1);
                        cnt      <= CW'(NS - 1);
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    if (cnt == '0) begin
                        res       <= rem_nxt[Q_LEN-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

    // A modulus with a clear top bit breaks the rem < q<<k invariant.
    a_qh_msb: assert property (@(posedge clk) disable iff (!rst)
        (state == IDLE && in_valid) |-> qH[TL_LEN-1]);

endmodule
